// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types and constants for the two-port RAM arbiter.
//                Holds the arbiter state encoding and the port identifiers
//                used to tag pending read returns.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Arbiter ownership state. OWN0/OWN1 are only reachable when the burst
    // lock feature (RAM_ARB_LOCK_EN) is compiled in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Port identifiers, used for the round-robin pointer and the read tag.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Width of the request/grant vectors between top and round-robin picker.
    localparam int unsigned C_NUM_PORTS = 2;

    // Returns the port index encoded in a one-hot grant vector.
    function automatic logic gnt_to_port(input logic [C_NUM_PORTS-1:0] gnt);
        return gnt[1] ? PORT1 : PORT0;
    endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_rr
//  Description : Two-way round-robin picker with a one-bit priority pointer.
//                A lone request is granted directly. On a conflict the port
//                named by the pointer wins; the pointer then flips to the
//                other port, but only when the caller says the pick was used
//                (i_advance), so grants suppressed by an owning burst do not
//                disturb fairness.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i      in   clock
//    rst_i      in   synchronous active-high reset (pointer -> port 0)
//    i_req      in   [1:0] request vector, bit p = port p
//    i_advance  in   pick is consumed this cycle
//    o_gnt      out  [1:0] one-hot grant (all zero when no request)
// ============================================================================
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [C_NUM_PORTS-1:0] i_req,
    input  logic                   i_advance,
    output logic [C_NUM_PORTS-1:0] o_gnt
);

    logic                   r_ptr_q;
    logic                   w_ptr_d;
    logic [C_NUM_PORTS-1:0] w_gnt;

    always_comb begin
        w_gnt   = 2'b00;
        w_ptr_d = r_ptr_q;
        case (i_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_ptr_q == PORT1) ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
        // Only a conflict resolved by the pointer moves it; uncontested
        // grants leave the priority where it was.
        if (i_advance && (i_req == 2'b11)) begin
            w_ptr_d = ~gnt_to_port(w_gnt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr_q <= PORT0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_gnt = w_gnt;

endmodule : ram_arb_rr
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one single-port RAM between a host port (port 0) and
//                an application port (port 1). Each port uses a valid/ready
//                handshake; at most one access reaches the RAM per cycle and
//                the RAM signals are muxed combinationally from the winner.
//                Read data (1-cycle RAM latency) is steered back to the port
//                that issued the read and held there between returns.
//  Revision    : 1.0 - initial release
//
//  Build option
//    RAM_ARB_LOCK_EN  defined  : lock_i honoured, a locked access keeps the
//                                RAM owned by that port (OWN0/OWN1).
//                     undefined: lock_i ignored, pure per-cycle round robin.
//
//  Ports
//    clk_i, rst_i           clock, synchronous active-high reset
//    pX_valid_i/ready_o     request handshake, transfer when both are high
//    pX_we_i                1 = write, 0 = read
//    pX_lock_i              keep ownership after this access
//    pX_addr_i/mask_i/wdata_i  access payload (mask passed through)
//    pX_rdata_o/rvalid_o    read return, rvalid pulses one cycle after accept
//    ram_*                  single-port RAM interface, same clock
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  p0_valid_i,
    output logic                  p0_ready_o,
    input  logic                  p0_we_i,
    input  logic                  p0_lock_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [WORD_WIDTH-1:0] p0_mask_i,
    input  logic [WORD_WIDTH-1:0] p0_wdata_i,
    output logic [WORD_WIDTH-1:0] p0_rdata_o,
    output logic                  p0_rvalid_o,

    input  logic                  p1_valid_i,
    output logic                  p1_ready_o,
    input  logic                  p1_we_i,
    input  logic                  p1_lock_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [WORD_WIDTH-1:0] p1_mask_i,
    input  logic [WORD_WIDTH-1:0] p1_wdata_i,
    output logic [WORD_WIDTH-1:0] p1_rdata_o,
    output logic                  p1_rvalid_o,

    output logic                  ram_clke_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_mask_o,
    output logic [WORD_WIDTH-1:0] ram_wdata_o,
    input  logic [WORD_WIDTH-1:0] ram_rdata_i
);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    arb_state_t            r_state_q,  w_state_d;
    logic                  r_rd_pend_q, w_rd_pend_d;
    logic                  r_rd_port_q, w_rd_port_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,   w_addr_d;
    logic [WORD_WIDTH-1:0] r_mask_q,   w_mask_d;
    logic [WORD_WIDTH-1:0] r_wdata_q,  w_wdata_d;
    logic [WORD_WIDTH-1:0] r_p0_rdata_q, w_p0_rdata_d;
    logic [WORD_WIDTH-1:0] r_p1_rdata_q, w_p1_rdata_d;

    logic [C_NUM_PORTS-1:0] w_rr_gnt;
    logic                   w_p0_ready, w_p1_ready;
    logic                   w_p0_xfer,  w_p1_xfer;
    logic                   w_ram_we;
    logic                   w_p0_rvalid, w_p1_rvalid;

    // ------------------------------------------------------------------
    // Round-robin pick, used only while nobody owns the RAM
    // ------------------------------------------------------------------
    ram_arb_rr u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     ({p1_valid_i, p0_valid_i}),
        .i_advance (r_state_q == IDLE),
        .o_gnt     (w_rr_gnt)
    );

    // ------------------------------------------------------------------
    // Grant / ready. Ready is forced low during reset so nothing is
    // accepted in a cycle whose state is about to be discarded.
    // ------------------------------------------------------------------
    always_comb begin
        w_p0_ready = 1'b0;
        w_p1_ready = 1'b0;
        if (!rst_i) begin
            case (r_state_q)
                IDLE: begin
                    w_p0_ready = w_rr_gnt[0];
                    w_p1_ready = w_rr_gnt[1];
                end
                OWN0:    w_p0_ready = p0_valid_i;
                OWN1:    w_p1_ready = p1_valid_i;
                default: begin
                    w_p0_ready = 1'b0;
                    w_p1_ready = 1'b0;
                end
            endcase
        end
    end

    assign w_p0_xfer = p0_valid_i & w_p0_ready;
    assign w_p1_xfer = p1_valid_i & w_p1_ready;

    // ------------------------------------------------------------------
    // Ownership FSM next state
    // ------------------------------------------------------------------
`ifdef RAM_ARB_LOCK_EN
    always_comb begin
        w_state_d = r_state_q;
        // An idle owner keeps ownership; only its own unlocked access
        // releases the RAM.
        if (w_p0_xfer) begin
            w_state_d = p0_lock_i ? OWN0 : IDLE;
        end else if (w_p1_xfer) begin
            w_state_d = p1_lock_i ? OWN1 : IDLE;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = p0_lock_i ^ p1_lock_i;

    always_comb begin
        w_state_d = IDLE;
    end
`endif

    // ------------------------------------------------------------------
    // RAM request mux. Payload holds the last granted values when idle so
    // the RAM pins do not toggle without an access.
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_we  = 1'b0;
        w_addr_d  = r_addr_q;
        w_mask_d  = r_mask_q;
        w_wdata_d = r_wdata_q;
        if (w_p0_xfer) begin
            w_ram_we  = p0_we_i;
            w_addr_d  = p0_addr_i;
            w_mask_d  = p0_mask_i;
            w_wdata_d = p0_wdata_i;
        end else if (w_p1_xfer) begin
            w_ram_we  = p1_we_i;
            w_addr_d  = p1_addr_i;
            w_mask_d  = p1_mask_i;
            w_wdata_d = p1_wdata_i;
        end
    end

    assign ram_clke_o  = w_p0_xfer | w_p1_xfer;
    assign ram_we_o    = w_ram_we;
    assign ram_addr_o  = w_addr_d;
    assign ram_mask_o  = w_mask_d;
    assign ram_wdata_o = w_wdata_d;

    // ------------------------------------------------------------------
    // Read return tracking. The tag is captured at accept time; the RAM
    // data arrives in the following cycle and is routed straight through.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_pend_d = (w_p0_xfer & ~p0_we_i) | (w_p1_xfer & ~p1_we_i);
        w_rd_port_d = w_p1_xfer ? PORT1 : PORT0;
    end

    // Reset in the return cycle drops the pending read.
    assign w_p0_rvalid = r_rd_pend_q & (r_rd_port_q == PORT0) & ~rst_i;
    assign w_p1_rvalid = r_rd_pend_q & (r_rd_port_q == PORT1) & ~rst_i;

    always_comb begin
        w_p0_rdata_d = r_p0_rdata_q;
        w_p1_rdata_d = r_p1_rdata_q;
        if (rst_i) begin
            w_p0_rdata_d = '0;
            w_p1_rdata_d = '0;
        end else begin
            if (w_p0_rvalid) begin
                w_p0_rdata_d = ram_rdata_i;
            end
            if (w_p1_rvalid) begin
                w_p1_rdata_d = ram_rdata_i;
            end
        end
    end

    assign p0_ready_o  = w_p0_ready;
    assign p1_ready_o  = w_p1_ready;
    assign p0_rvalid_o = w_p0_rvalid;
    assign p1_rvalid_o = w_p1_rvalid;
    assign p0_rdata_o  = w_p0_rdata_d;
    assign p1_rdata_o  = w_p1_rdata_d;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= IDLE;
            r_rd_pend_q  <= 1'b0;
            r_rd_port_q  <= PORT0;
            r_addr_q     <= '0;
            r_mask_q     <= '0;
            r_wdata_q    <= '0;
            r_p0_rdata_q <= '0;
            r_p1_rdata_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_rd_pend_q  <= w_rd_pend_d;
            r_rd_port_q  <= w_rd_port_d;
            r_addr_q     <= w_addr_d;
            r_mask_q     <= w_mask_d;
            r_wdata_q    <= w_wdata_d;
            r_p0_rdata_q <= w_p0_rdata_d;
            r_p1_rdata_q <= w_p1_rdata_d;
        end
    end

endmodule : ram_arbiter
`default_nettype wire
